pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Fetch-side program-counter controller for the single-issue MIPS-style core. It owns the PC register and resolves the next-PC select from jr/j/branch. The select is encoded 11 jr, 10 j, 01 taken branch, 00 sequential. It handshakes with instruction memory, holds on decode hazards, and issues a one-cycle flush bubble after every taken control transfer. It sits between the control unit/ALU zero flag and the instruction memory port.

Parameters:
WIDTH, 32, PC and target width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  decode hazard; hold current PC/instruction
jr  in  1  current instruction is jump-register
j  in  1  current instruction is jump
branch  in  1  current instruction is conditional branch
zero  in  1  ALU zero flag for branch condition
branch_target  in  WIDTH  branch destination
jump_target  in  WIDTH  jump destination
jr_target  in  WIDTH  register-sourced destination
imem_ready  in  1  instruction memory has returned data for pc
pc  out  WIDTH  current fetch address
imem_req  out  1  fetch request for pc
instr_valid  out  1  fetched instruction at pc is valid this cycle
pcsrc  out  2  registered select of the last PC update
flush  out  1  discard the instruction in decode

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=BOOT, pcsrc=00, imem_req=0, instr_valid=0, flush=0.
- States: BOOT, FETCH, HOLD, REDIRECT.
- BOOT: lasts exactly one cycle after reset deasserts, with imem_req=0, then goes to FETCH.
- FETCH: imem_req=1.
  - imem_ready=0: pc is held and the state stays FETCH.
  - imem_ready=1 with stall=1: instr_valid=1 and the state goes to HOLD with pc held.
  - imem_ready=1 with stall=0: this is a completion. instr_valid=1 and the next-PC select is applied.
- HOLD: imem_req=0 and instr_valid=1; the instruction stays presented.
  - stall=1: remain in HOLD.
  - stall=0: completion. Apply the next-PC select, ignoring imem_ready.
- Next-PC select is evaluated only at completion, using jr/j/branch/zero/targets sampled that cycle. Priority:
  - jr=1: pc<=jr_target, pcsrc<=11.
  - else j=1: pc<=jump_target, pcsrc<=10.
  - else branch&zero: pc<=branch_target, pcsrc<=01.
  - else: pc<=pc+STEP, pcsrc<=00. Modulo 2^WIDTH, wraps silently at all-ones boundary.
- Transitions after completion:
  - taken (pcsrc≠00): go to REDIRECT.
  - sequential: stay in or return to FETCH.
- REDIRECT: one cycle. flush=1, imem_req=0, instr_valid=0, imem_ready ignored, then go to FETCH.
- flush is asserted only in REDIRECT.
- Control inputs outside completion cycles are don't-care. branch with zero=0 is sequential, and there is no flush.
- Simultaneous jr and j and branch: jr wins; j wins over branch.
- Outputs pc, pcsrc and flush are registered or decoded from state only. No combinational path from inputs to imem_req or flush.
- Reset mid-fetch or mid-REDIRECT: the fetch is abandoned immediately, with no flush pulse on reset release.

Test Plan:
- Reset release, imem_ready=1 every cycle, no control → BOOT one cycle, then pc 0x0,0x4,0x8,0xC on consecutive cycles, pcsrc=00, flush never 1.
- At pc=0x8 completion with j=1, jump_target=0x100 → next cycle pc=0x100, pcsrc=10, flush=1 for exactly one cycle, imem_req=0 in that cycle; fetch of 0x100 the cycle after.
- jr=1, j=1, branch=1, zero=1 simultaneously with jr_target=0x40, jump_target=0x80, branch_target=0xC0 → pc=0x40, pcsrc=11.
- branch=1, zero=0 at pc=0x10 → pc=0x14, pcsrc=00, no flush; repeat with zero=1, branch_target=0x200 → pc=0x200, pcsrc=01, flush pulse.
- imem_ready low 3 cycles at pc=0x20, then high with stall=1 for 2 cycles → pc stays 0x20 throughout, instr_valid=1 during the 2 stall cycles, then pc=0x24 after stall drops.
- Other cases → each must hold as stated:
  - WIDTH=32, pc=0xFFFF_FFFC, sequential → pc=0x0000_0000.
  - Reset asserted during REDIRECT → pc=RESET_PC and flush=0 immediately (same cycle, asynchronously).

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-side PC controller: owns the PC, resolves jr/j/branch redirects,
// handshakes with instruction memory and emits a flush bubble after taken transfers.
module pc_sequencer #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      STEP     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jr,
    input  logic             j,
    input  logic             branch,
    input  logic             zero,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] pc,
    output logic             imem_req,
    output logic             instr_valid,
    output logic [1:0]       pcsrc,
    output logic             flush
);

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_FETCH    = 2'd1,
        S_HOLD     = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_JR     = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [1:0]       pcsrc_q, pcsrc_d;
    logic             complete;
    logic [WIDTH-1:0] next_pc;
    logic [1:0]       next_src;

    // Next-PC select: jr over j over taken branch over sequential.
    always_comb begin
        next_pc  = pc_q + WIDTH'(STEP);
        next_src = SRC_SEQ;
        if (jr) begin
            next_pc  = jr_target;
            next_src = SRC_JR;
        end else if (j) begin
            next_pc  = jump_target;
            next_src = SRC_JUMP;
        end else if (branch && zero) begin
            next_pc  = branch_target;
            next_src = SRC_BRANCH;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pcsrc_d     = pcsrc_q;
        complete    = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        flush       = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_valid = 1'b1;
                    if (stall) begin
                        state_d = S_HOLD;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    complete = 1'b1;
                end
            end
            S_REDIRECT: begin
                flush   = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        // A completed instruction commits the PC; taken transfers cost one bubble.
        if (complete) begin
            pc_d    = next_pc;
            pcsrc_d = next_src;
            state_d = (next_src != SRC_SEQ) ? S_REDIRECT : S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            pcsrc_q <= SRC_SEQ;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pcsrc_q <= pcsrc_d;
        end
    end

    assign pc    = pc_q;
    assign pcsrc = pcsrc_q;

endmodule
